jk_excite_driver: RTL

JK_EXCITE_DRIVER -- requirements
Module: jk_excite_driver

---
 rtl/jk_pkg.sv | 31 +++
 rtl/jk_excite_cell.sv | 21 ++
 rtl/jk_excite_driver.sv | 119 +++++++++++
 3 files changed

// File: rtl/jk_pkg.sv
// Shared types and excitation constants for the JK bank driver.
package jk_pkg;

    // Driver sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CHECK = 2'd2
    } jk_state_e;

    // Excitation pairs, packed as {J, K}.
    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_RESET  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

    // Excitation needed to move one flip-flop from q to d.
    function automatic logic [1:0] jk_excite(input logic q, input logic d, input logic toggle);
        logic [1:0] v_jk;
        if (q == d)
            v_jk = JK_HOLD;
        else if (toggle)
            v_jk = JK_TOGGLE;
        else if (d)
            v_jk = JK_SET;
        else
            v_jk = JK_RESET;
        return v_jk;
    endfunction

endpackage

// File: rtl/jk_excite_cell.sv
// One-bit JK excitation: combinational mapping from (q, d, toggle) to (j, k).
module jk_excite_cell
    import jk_pkg::*;
(
    input  logic q,
    input  logic d,
    input  logic toggle,
    output logic j,
    output logic k
);

    logic [1:0] w_jk;

    // Look up the {J, K} pair for this bit.
    always_comb begin
        w_jk = jk_excite(q, d, toggle);
        j    = w_jk[1];
        k    = w_jk[0];
    end

endmodule

// File: rtl/jk_excite_driver.sv
// Drives an external JK flip-flop bank toward a requested state, checks the
// result on q_fb and re-drives a bounded number of times before giving up.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | waiting for a target; tgt_ready high, j/k held at zero
//   ST_DRIVE | one cycle of excitation computed from q_fb and the target
//   ST_CHECK | compare q_fb with the target; finish, retry or report error
module jk_excite_driver
    import jk_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MAX_RETRY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tgt_valid,
    input  logic [WIDTH-1:0] tgt_data,
    output logic             tgt_ready,
    input  logic             toggle_mode,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [7:0]       mismatch_cnt
);

    // Retry counter must be able to hold MAX_RETRY itself.
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

    jk_state_e        r_state;
    logic [WIDTH-1:0] r_tgt;
    logic             r_tog;
    logic [RW-1:0]    r_retry;
    logic             r_done;
    logic             r_err;
    logic [7:0]       r_mcnt;

    logic [WIDTH-1:0] w_j_cell;
    logic [WIDTH-1:0] w_k_cell;
    logic             w_drive;
    logic             w_match;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
        jk_excite_cell u_cell (
            .q      (q_fb[gi]),
            .d      (r_tgt[gi]),
            .toggle (r_tog),
            .j      (w_j_cell[gi]),
            .k      (w_k_cell[gi])
        );
    end

    // Excitation only reaches the bank during DRIVE; otherwise hold.
    always_comb begin
        w_drive = (r_state == ST_DRIVE);
        w_match = (q_fb == r_tgt);
        j       = w_drive ? w_j_cell : '0;
        k       = w_drive ? w_k_cell : '0;
    end

    assign tgt_ready    = (r_state == ST_IDLE);
    assign busy         = (r_state != ST_IDLE);
    assign done         = r_done;
    assign err          = r_err;
    assign mismatch_cnt = r_mcnt;

    // Sequencer: accept, drive, check, retry, and result pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_tgt   <= '0;
            r_tog   <= 1'b0;
            r_retry <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_mcnt  <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (tgt_valid) begin
                        r_tgt   <= tgt_data;
                        r_tog   <= toggle_mode;
                        r_retry <= '0;
                        r_state <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    r_state <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (w_match) begin
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        if (r_mcnt != 8'hFF)
                            r_mcnt <= r_mcnt + 8'd1;
                        if (r_retry < RETRY_LIMIT) begin
                            r_retry <= r_retry + RW'(1);
                            r_state <= ST_DRIVE;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
